// File: rtl/hdmi_init_pkg.sv
// ADV7513 power-up register table, table entry type and sequencer states.
// Latency: n/a (constants and a combinational table lookup only).
// Backpressure: n/a.
package hdmi_init_pkg;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } init_entry_t;

  localparam int INIT_LEN = 12;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_PEND    = 3'd2,
    ST_GAP     = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } init_state_t;

  // Power-up, input format, output format, clocking and HDMI-mode registers.
  localparam init_entry_t [0:INIT_LEN-1] INIT_TABLE = '{
    '{8'h41, 8'h10}, '{8'h98, 8'h03}, '{8'h9A, 8'hE0}, '{8'h9C, 8'h30},
    '{8'h9D, 8'h61}, '{8'hA2, 8'hA4}, '{8'hA3, 8'hA4}, '{8'hE0, 8'hD0},
    '{8'hF9, 8'h00}, '{8'h15, 8'h00}, '{8'h16, 8'h30}, '{8'hAF, 8'h06}
  };

  // Out-of-range indices return an all-zero entry rather than wrapping.
  function automatic init_entry_t init_entry(input logic [3:0] i);
    if (int'(i) < INIT_LEN) return INIT_TABLE[i];
    return '0;
  endfunction

endpackage

// File: rtl/hpd_debounce.sv
// Hot-plug detect conditioner: 2-flop synchronizer followed by a stability debouncer.
// Latency: 2 sync cycles + DEBOUNCE stable cycles from raw change to stable/rise.
// Backpressure: none; rise is a single-cycle pulse on accepted 0->1 changes only.
module hpd_debounce #(
  parameter logic [7:0] DEBOUNCE = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;
  logic       cnt_full;

  assign cnt_full = ({1'b0, cnt} + 9'd1) >= {1'b0, DEBOUNCE};

  // Bring the asynchronous connector pin into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it differs from the current one long enough;
  // any return to the old level throws the partial count away.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      rise   <= 1'b0;
      cnt    <= 8'd0;
    end else begin
      rise <= 1'b0;
      if (sync2 == stable) begin
        cnt <= 8'd0;
      end else if (cnt_full) begin
        stable <= sync2;
        rise   <= sync2;
        cnt    <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/hdmi_init_seq.sv
// ADV7513 configuration sequencer: walks INIT_TABLE, one I2C write per entry, with NACK retry.
// Latency: first wr_req POWERUP_CYCLES+1 edges after reset; next request 2 edges after wr_done.
// Backpressure: wr_req is held with stable fields until wr_done; reinit waits for in-flight writes.
module hdmi_init_seq
  import hdmi_init_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR       = 8'h72,
  parameter logic [15:0] POWERUP_CYCLES = 16'd4190,
  parameter logic [15:0] BACKOFF_CYCLES = 16'd419,
  parameter logic [1:0]  MAX_RETRY      = 2'd3,
  parameter logic [7:0]  HPD_DEBOUNCE   = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hpd,
  input  logic       restart,
  output logic       wr_req,
  output logic [7:0] wr_dev,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  input  logic       wr_done,
  input  logic       wr_nack,
  output logic       busy,
  output logic       init_done,
  output logic       init_err,
  output logic [3:0] idx
);

  init_state_t state;
  init_entry_t cur;
  logic [15:0] cnt;
  logic [1:0]  retry;
  logic        pend_reinit;
  logic        hpd_rise;
  // Only the rising edge matters here; the debounced level itself is not consumed.
  logic        hpd_level_unused;
  logic        trig;
  logic        reinit;
  logic        last_entry;
  logic        retry_exhaust;

  hpd_debounce #(.DEBOUNCE(HPD_DEBOUNCE)) u_hpd (
    .clk    (clk),
    .rst    (rst),
    .raw    (hpd),
    .stable (hpd_level_unused),
    .rise   (hpd_rise)
  );

  assign wr_dev        = DEV_ADDR;
  assign cur           = init_entry(idx);
  assign trig          = restart | hpd_rise;
  assign last_entry    = (idx == 4'(INIT_LEN - 1));
  assign retry_exhaust = ((retry + 2'd1) == MAX_RETRY);
  assign busy          = (state != ST_DONE) && (state != ST_ERROR);

  // A reinit request takes effect at once unless a write is outstanding, in which
  // case it is parked in pend_reinit and honoured when that write completes.
  always_comb begin
    reinit = 1'b0;
    case (state)
      ST_ISSUE: reinit = 1'b0;
      ST_PEND:  reinit = wr_done & (pend_reinit | trig);
      default:  reinit = trig;
    endcase
  end

  // Sequencer state, table walk, retry bookkeeping and registered write request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_WAIT;
      cnt         <= POWERUP_CYCLES;
      idx         <= 4'd0;
      retry       <= 2'd0;
      pend_reinit <= 1'b0;
      wr_req      <= 1'b0;
      wr_reg      <= 8'd0;
      wr_data     <= 8'd0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
    end else if (reinit) begin
      state       <= ST_WAIT;
      cnt         <= POWERUP_CYCLES;
      idx         <= 4'd0;
      retry       <= 2'd0;
      pend_reinit <= 1'b0;
      wr_req      <= 1'b0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          // Leaving one count early lets the registered wr_req land on edge POWERUP_CYCLES+1.
          if (cnt <= 16'd1) state <= ST_ISSUE;
          else              cnt   <= cnt - 16'd1;
        end
        ST_ISSUE: begin
          wr_req  <= 1'b1;
          wr_reg  <= cur.addr;
          wr_data <= cur.data;
          state   <= ST_PEND;
          if (trig) pend_reinit <= 1'b1;
        end
        ST_PEND: begin
          if (trig) pend_reinit <= 1'b1;
          if (wr_done) begin
            wr_req <= 1'b0;
            if (!wr_nack) begin
              retry <= 2'd0;
              if (last_entry) begin
                state     <= ST_DONE;
                init_done <= 1'b1;
              end else begin
                idx   <= idx + 4'd1;
                state <= ST_GAP;
              end
            end else if (retry_exhaust) begin
              state    <= ST_ERROR;
              init_err <= 1'b1;
            end else begin
              retry <= retry + 2'd1;
              cnt   <= BACKOFF_CYCLES;
              state <= ST_BACKOFF;
            end
          end
        end
        ST_GAP: state <= ST_ISSUE;
        ST_BACKOFF: begin
          if (cnt <= 16'd1) state <= ST_ISSUE;
          else              cnt   <= cnt - 16'd1;
        end
        ST_DONE, ST_ERROR: state <= state;
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: doc/hdmi_init_seq.md
# hdmi_init_seq

Power-up and hot-plug configuration sequencer for the ADV7513 HDMI transmitter. Walks a fixed table of register writes and hands each one to the byte-level I2C write master through a request/done handshake. Retries NACKed writes and re-runs the whole table on a debounced hot-plug rising edge or an explicit restart. Sits between board reset/HPD and the I2C master. It must report `init_done` before the HDMI video path is considered live.

## Interface
Parameters:
- `DEV_ADDR`, 8'h72: ADV7513 8-bit write address, driven on `wr_dev`.
- `POWERUP_CYCLES`, 16'd4190: wait after reset or restart before the first write (~1 ms at 4.19 MHz).
- `BACKOFF_CYCLES`, 16'd419: wait after a NACK before reissuing the same entry.
- `MAX_RETRY`, 2'd3: NACKs tolerated per entry before error.
- `HPD_DEBOUNCE`, 8'd255: cycles `hpd` must be stable before the change is accepted.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `hpd` in 1: raw hot-plug detect from the connector (asynchronous).
- `restart` in 1: single-cycle request to rerun the table.
- `wr_req` out 1: write request, held high until `wr_done`.
- `wr_dev` out 8: device address, constant `DEV_ADDR`.
- `wr_reg` out 8: register address of the current entry.
- `wr_data` out 8: data byte of the current entry.
- `wr_done` in 1: one-cycle pulse from the I2C master when the write finishes.
- `wr_nack` in 1: valid only with `wr_done`; 1 means the slave NACKed.
- `busy` out 1: sequence in progress (any state except DONE and ERROR).
- `init_done` out 1: table written successfully.
- `init_err` out 1: an entry exceeded `MAX_RETRY`.
- `idx` out 4: current table index (debug, shown on 7-segment).

## Operation
- FSM states: WAIT, ISSUE, PEND, GAP, BACKOFF, DONE, ERROR.
- WAIT: load counter with `POWERUP_CYCLES`, count to 0, go to ISSUE. `idx`=0 and retry count=0 on entry.
- ISSUE: assert `wr_req` with `wr_reg`/`wr_data` = `INIT_TABLE[idx]`, go to PEND.
- PEND: hold `wr_req` and the fields stable until `wr_done`.
  - `wr_done & ~wr_nack`: clear retry count. If `idx==INIT_LEN-1`, go to DONE. Otherwise `idx++` and go to GAP.
  - `wr_done & wr_nack`: if retry count reaches `MAX_RETRY` (checked after increment), go to ERROR. Otherwise increment and go to BACKOFF.
- GAP: one idle cycle with `wr_req`=0, then ISSUE.
- BACKOFF: count `BACKOFF_CYCLES`, then ISSUE with the same `idx`.
- DONE: `init_done`=1. ERROR: `init_err`=1; `idx` holds the failing entry.
- Reinit trigger = `restart` or a debounced `hpd` rising edge.
  - In DONE, ERROR, WAIT, GAP or BACKOFF: go to WAIT next cycle, clear `init_done`/`init_err`.
  - In ISSUE or PEND: latch a pending flag. Never abort an in-flight write. On `wr_done`, go to WAIT regardless of `wr_nack` or `idx`.
- HPD path: 2-flop synchronizer, then debouncer. A falling edge is accepted silently and triggers nothing.
- `wr_done` outside PEND is ignored.

## Timing
- Reset values: `wr_req`=0, `wr_reg`=0, `wr_data`=0, `busy`=1, `init_done`=0, `init_err`=0, `idx`=0. State=WAIT, debounced hpd=0.
- First `wr_req` rises at clock edge `POWERUP_CYCLES`+1 after the first edge sampling `rst`=0.
- `wr_done` sampled at edge N: `wr_req` low from edge N, next `wr_req` high at edge N+2. A request never stays high across a `wr_done` edge.
- `init_done` rises at the same edge that samples the final `wr_done`.
- HPD acceptance latency: 2 synchronizer cycles + `HPD_DEBOUNCE` stable cycles. Any glitch restarts the debounce count.
- `rst` mid-write: immediate return to reset values. The I2C master is reset by the same `rst`.

## Structure
- Package `hdmi_init_pkg` holds:
  - `init_entry_t` (8-bit reg, 8-bit data), `INIT_LEN`=12, state enum `init_state_t`.
  - `INIT_TABLE`: {41,10} {98,03} {9A,E0} {9C,30} {9D,61} {A2,A4} {A3,A4} {E0,D0} {F9,00} {15,00} {16,30} {AF,06} (hex).
- Sub-module `hpd_debounce` (clk, rst, raw in, stable out, rise pulse out) contains the synchronizer and counter.

## Test plan
- Reset release, master acks every write after 20 cycles -> 12 requests in table order, first (41,10) at edge 4191, last (AF,06). `init_done`=1, `busy`=0, `idx`=11.
- NACK entry 3 twice, then ack -> (9C,30) issued 3 times, each reissue `BACKOFF_CYCLES`+1 cycles after the NACK. Sequence completes, `init_err`=0.
- NACK entry 5 on every attempt -> exactly 3 attempts, then `init_err`=1, `idx`=5, `busy`=0, no further `wr_req`.
- `hpd` 0->1 held 300 cycles while in DONE -> `init_done` drops, full table rewritten. A 100-cycle `hpd` pulse -> no reinit.
- `restart` pulsed while PEND on entry 7 -> `wr_req` stays high until `wr_done`. Then WAIT and restart from `idx`=0. Entry 8 is never issued.
- `rst` asserted in PEND -> next edge `wr_req`=0, `idx`=0, `busy`=1. Full power-up wait repeats.
